// File: rtl/mux_scan_pkg.sv
// rtl/mux_scan_pkg.sv - shared constants and state type for the mux scan sequencer
package mux_scan_pkg;

  localparam int NCH   = 8;
  localparam int SEL_W = 3;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/next_chan_find.sv
// rtl/next_chan_find.sv - finds the next enabled channel strictly above an index
module next_chan_find
  import mux_scan_pkg::*;
(
  input  logic [NCH-1:0]   mask,
  input  logic [SEL_W-1:0] idx,
  input  logic             first,
  output logic             found,
  output logic [SEL_W-1:0] nxt
);

  // Walk downwards so the lowest qualifying channel is the one left in nxt;
  // `first` treats idx as -1 so channel 0 is eligible.
  always_comb begin
    found = 1'b0;
    nxt   = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (mask[i] && (first || (i > int'(idx)))) begin
        found = 1'b1;
        nxt   = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// rtl/mux_scan_ctrl.sv - scans a masked set of 8:1 mux channels and reports changes
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic [NCH-1:0]   mask,
  input  logic             mux_out,
  output logic [SEL_W-1:0] sel,
  output logic             busy,
  output logic             done,
  output logic [NCH-1:0]   sample,
  output logic [NCH-1:0]   changed
);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t            state_q, state_nx;
  logic [CNT_W-1:0]  cnt_q, cnt_nx;
  logic [NCH-1:0]    mask_q, mask_nx;
  logic [SEL_W-1:0]  sel_nx;
  logic              cap_en;
  logic              clr_chg;

  logic              first_found;
  logic [SEL_W-1:0]  first_idx;
  logic              next_found;
  logic [SEL_W-1:0]  next_idx;

  // First channel of a new scan comes from the live mask, since it is latched on that same edge.
  next_chan_find u_first (
    .mask  (mask),
    .idx   ('0),
    .first (1'b1),
    .found (first_found),
    .nxt   (first_idx)
  );

  // Successor of the channel just captured, within the mask latched for this scan.
  next_chan_find u_next (
    .mask  (mask_q),
    .idx   (sel),
    .first (1'b0),
    .found (next_found),
    .nxt   (next_idx)
  );

  // Next-state logic; abort overrides everything, including a pending capture.
  always_comb begin
    state_nx = state_q;
    cnt_nx   = cnt_q;
    mask_nx  = mask_q;
    sel_nx   = sel;
    cap_en   = 1'b0;
    clr_chg  = 1'b0;
    if (abort && (state_q != IDLE)) begin
      state_nx = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            clr_chg = 1'b1;
            if (first_found) begin
              state_nx = SETTLE;
              mask_nx  = mask;
              sel_nx   = first_idx;
              cnt_nx   = '0;
            end else begin
              state_nx = DONE;
            end
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            state_nx = CAPTURE;
          end else begin
            cnt_nx = cnt_q + 1'b1;
          end
        end
        CAPTURE: begin
          cap_en = 1'b1;
          if (next_found) begin
            state_nx = SETTLE;
            sel_nx   = next_idx;
            cnt_nx   = '0;
          end else begin
            state_nx = DONE;
          end
        end
        DONE: begin
          if (cont && first_found) begin
            clr_chg  = 1'b1;
            state_nx = SETTLE;
            mask_nx  = mask;
            sel_nx   = first_idx;
            cnt_nx   = '0;
          end else begin
            state_nx = IDLE;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // State, counter, select and status registers; busy/done are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mask_q  <= '0;
      sel     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_nx;
      cnt_q   <= cnt_nx;
      mask_q  <= mask_nx;
      sel     <= sel_nx;
      busy    <= (state_nx == SETTLE) || (state_nx == CAPTURE);
      done    <= (state_nx == DONE);
    end
  end

  // Capture registers: only the selected channel's bits move on a capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample  <= '0;
      changed <= '0;
    end else if (clr_chg) begin
      changed <= '0;
    end else if (cap_en) begin
      sample[sel]  <= mux_out;
      changed[sel] <= mux_out ^ sample[sel];
    end
  end

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb/tb_mux_scan_ctrl.sv - scoreboard bench for the mux scan sequencer
module tb_mux_scan_ctrl;

  localparam int S = 2;

  typedef struct {
    logic [7:0] s;
    logic [7:0] c;
    int         t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] mask = 8'h00;
  logic [7:0] data = 8'h00;
  logic       mux_out;
  logic [2:0] sel;
  logic       busy;
  logic       done;
  logic [7:0] sample;
  logic [7:0] changed;

  int   cyc = 0;
  int   total = 0;
  int   passed = 0;
  exp_t q[$];

  mux_scan_ctrl #(.SETTLE_CYCLES(S)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .abort   (abort),
    .cont    (cont),
    .mask    (mask),
    .mux_out (mux_out),
    .sel     (sel),
    .busy    (busy),
    .done    (done),
    .sample  (sample),
    .changed (changed)
  );

  // 8:1 mux with {S0,S1,S2} = sel, S0 the most significant select bit
  assign mux_out = data[sel];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (q.size() == 0) begin
        chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("done_time", 32'(cyc), 32'(e.t));
        chk("sample", 32'(sample), 32'(e.s));
        chk("changed", 32'(changed), 32'(e.c));
        chk("busy_in_done", 32'(busy), 32'd0);
      end
    end
  end

  task automatic scan(input logic [7:0] m, input logic [7:0] d,
                      input logic [7:0] es, input logic [7:0] ec, input logic poke);
    int   chans[$];
    exp_t e;
    int   c0;
    for (int i = 0; i < 8; i++) if (m[i]) chans.push_back(i);
    @(negedge clk);
    mask = m; data = d; start = 1'b1; c0 = cyc;
    e.s = es; e.c = ec; e.t = c0 + 1 + chans.size() * (S + 1);
    q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    foreach (chans[j]) begin
      chk("sel_step", 32'(sel), 32'(chans[j]));
      chk("busy_scan", 32'(busy), 32'd1);
      if (poke && j == 2) begin
        start = 1'b1; mask = 8'h01;
      end
      @(negedge clk);
      start = 1'b0; mask = m;
      repeat (S) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   c0;
    repeat (3) @(negedge clk);
    chk("rst_sel", 32'(sel), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sample", 32'(sample), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    scan(8'hFF, 8'hA5, 8'hA5, 8'hA5, 1'b0);
    scan(8'hFF, 8'hA4, 8'hA4, 8'h01, 1'b0);
    scan(8'hFF, 8'hA4, 8'hA4, 8'h00, 1'b0);
    scan(8'h81, 8'h5A, 8'h24, 8'h80, 1'b0);
    scan(8'h00, 8'hFF, 8'h24, 8'h00, 1'b0);
    scan(8'hFF, 8'hFF, 8'hFF, 8'hDB, 1'b1);

    // abort during SETTLE of channel 2 (edge 7)
    @(negedge clk);
    mask = 8'hFF; data = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sel", 32'(sel), 32'd2);
    repeat (30) @(negedge clk);
    chk("abort_sample", 32'(sample), 32'hFC);
    chk("abort_changed", 32'(changed), 32'h03);
    chk("abort_idle", 32'(busy), 32'd0);

    // asynchronous reset mid-scan
    @(negedge clk);
    mask = 8'hFF; data = 8'hAA; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_sel", 32'(sel), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_sel", 32'(sel), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_sample", 32'(sample), 32'd0);
    chk("arst_changed", 32'(changed), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // continuous mode, mask 0F: 13-cycle period
    @(negedge clk);
    mask = 8'h0F; data = 8'h0F; cont = 1'b1; start = 1'b1; c0 = cyc;
    e.s = 8'h0F; e.c = 8'h0F; e.t = c0 + 1 + 12; q.push_back(e);
    e.s = 8'h0F; e.c = 8'h00; e.t = c0 + 1 + 25; q.push_back(e);
    e.s = 8'h0F; e.c = 8'h00; e.t = c0 + 1 + 38; q.push_back(e);
    @(negedge clk);
    start = 1'b0;
    while (cyc < c0 + 1 + 11) @(negedge clk);
    chk("cont_busy_before", 32'(busy), 32'd1);
    @(negedge clk);
    chk("cont_busy_gap", 32'(busy), 32'd0);
    @(negedge clk);
    chk("cont_busy_after", 32'(busy), 32'd1);
    chk("cont_sel_restart", 32'(sel), 32'd0);
    while (cyc < c0 + 1 + 26) @(negedge clk);
    cont = 1'b0;
    while (cyc < c0 + 1 + 45) @(negedge clk);
    chk("cont_stopped", 32'(busy), 32'd0);

    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequencer that drives the select lines of the team's 8:1 single-bit multiplexer and captures its output. It walks through a masked set of the eight channels, waits a programmable settle time on each one, samples the mux output and assembles an 8-bit snapshot. For each scan it also reports which channels changed since the previous scan. It sits directly upstream of the mux on the select path and consumes the mux output.

## Interface
Parameters:
- SETTLE_CYCLES, 2, cycles `sel` is held stable before the capture cycle; legal range 1..15.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a scan; honoured only in IDLE.
- abort  in  1  terminate the scan in progress; return to IDLE with no `done`.
- cont  in  1  continuous mode; a new scan starts automatically after each `done`.
- mask  in  8  channel enable, bit i = channel i; latched when a scan starts.
- mux_out  in  1  output of the 8:1 mux.
- sel  out  3  channel select. Connect as {S0,S1,S2} = sel, so S0 = sel[2].
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse; `sample` and `changed` are valid during it.
- sample  out  8  last captured value per channel.
- changed  out  8  channels captured in this scan whose value differs from the previous `sample`.

## Operation
- Reset values: IDLE state, sel=0, busy=0, done=0, sample=8'h00, changed=8'h00, settle counter=0, latched mask=0.
- States:
  - IDLE: waits for `start`.
  - SETTLE: holds `sel` for SETTLE_CYCLES cycles.
  - CAPTURE: samples `mux_out` for the current channel.
  - DONE: one cycle with `done` high.
- IDLE -> SETTLE when start=1 and mask≠0:
  - latch mask;
  - sel = lowest enabled channel;
  - clear `changed`;
  - busy=1.
- IDLE -> DONE when start=1 and mask=0:
  - `changed` is cleared;
  - `sample` is untouched.
- SETTLE -> CAPTURE after SETTLE_CYCLES cycles in SETTLE.
- At the end of CAPTURE:
  - sample[sel] <= mux_out;
  - changed[sel] <= mux_out ^ old sample[sel];
  - if a higher enabled channel exists: go to SETTLE with sel = that channel;
  - otherwise: go to DONE.
- DONE -> SETTLE (rescan, re-latching the current `mask`) if cont=1 and mask≠0; otherwise DONE -> IDLE.
- Channels that are masked off are never selected, and their `sample` and `changed` bits are not modified.
- start while busy: ignored.
- abort (any state except IDLE):
  - next state is IDLE and busy=0;
  - no `done` pulse;
  - channels already captured keep their new values;
  - `sel` holds.
- abort takes priority over every other transition, including a CAPTURE that coincides with it (that capture is discarded).
- Asserting rst_n low mid-scan forces all reset values immediately.

## Timing
- Edge 0 samples start=1. Edges are numbered from it.
- Each enabled channel occupies SETTLE_CYCLES+1 cycles.
- With N enabled channels, the final capture happens at edge N·(SETTLE_CYCLES+1).
- `done` is high during the cycle that follows that edge; busy falls at the same edge.
- mask=0: `done` is high during the cycle after edge 0.
- `sel` changes only on the edge that enters SETTLE, so it is stable for at least SETTLE_CYCLES+1 cycles before capture.
- In continuous mode, busy stays low for exactly the one DONE cycle between scans.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package mux_scan_pkg holds:
  - NCH=8;
  - SEL_W=3;
  - the state enum {IDLE, SETTLE, CAPTURE, DONE};
  - SETTLE counter width 4.
- One combinational sub-module, next_chan_find:
  - inputs: latched mask[7:0] and current index[2:0];
  - outputs: found flag and the next enabled index strictly above the current one;
  - also reused with index = "-1" (a dedicated `first` input) for the initial channel.
- FSM, settle counter and capture registers live in mux_scan_ctrl.

## Test plan
With SETTLE_CYCLES=2, the bench drives the actual 8:1 mux with D=data[7:0].
- Full scan: reset, mask=FF, data=A5, start pulse -> `sel` steps 0..7, `done` in the cycle after edge 24, sample=A5, changed=A5.
- Change detection: repeat with data=A4 -> sample=A4, changed=01; repeat again unchanged -> changed=00.
- Sparse mask: mask=81 -> `sel` visits only 0 and 7, `done` after edge 6, sample bits 1..6 unchanged.
- Empty mask and busy start: mask=00 -> `done` after edge 0 with no SETTLE; start asserted mid-scan -> no effect on sequence or `done` timing.
- Abort and reset: abort at edge 7 of a mask=FF scan -> IDLE, no `done`, only sample[1:0] updated; rst_n low mid-scan -> all outputs at reset values asynchronously.
- Continuous mode: cont=1, mask=0F -> `done` pulses every 13 cycles, busy low for exactly one cycle between scans.
